// File: rtl/serial_cond_eval_pkg.sv
// Shared constants and types for the multi-word sign/condition evaluator.
package serial_cond_eval_pkg;

  localparam logic [2:0] COND_LT  = 3'b100;
  localparam logic [2:0] COND_EQ  = 3'b010;
  localparam logic [2:0] COND_GT  = 3'b001;
  localparam logic [2:0] COND_JMP = COND_LT | COND_EQ | COND_GT;

  typedef enum logic {ACC, HOLD} state_t;

  // Word-counter width: must hold the values 0..max_words.
  function automatic int cw_of(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/serial_cond_eval_if.sv
// Word-stream input and result handshake bundle for serial_cond_eval.
interface serial_cond_eval_if
  import serial_cond_eval_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 4
);
  localparam int CW = cw_of(MAX_WORDS);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_last;
  logic [2:0]              in_cond;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_lt;
  logic                    out_eq;
  logic                    out_gt;
  logic                    out_jump;
  logic [CW-1:0]           out_words;
  logic                    out_err;

  modport master (
    output in_valid, in_data, in_last, in_cond, out_ready,
    input  in_ready, out_valid, out_lt, out_eq, out_gt, out_jump, out_words, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_cond, out_ready,
    output in_ready, out_valid, out_lt, out_eq, out_gt, out_jump, out_words, out_err
  );

endinterface

// File: rtl/serial_cond_eval_word_flag_slice.sv
// Combinational per-word flag logic: folds one word into the zero accumulator
// and derives lt/eq/gt/jump as if this word were the most-significant one.
module word_flag_slice
  import serial_cond_eval_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] data,
  input  logic                    zero_in,
  input  logic [2:0]              cond,
  output logic                    zero_out,
  output logic                    lt,
  output logic                    eq,
  output logic                    gt,
  output logic                    jump
);

  assign zero_out = zero_in && (data == '0);
  assign lt       = data[WIDTH-1];
  assign eq       = zero_out;
  assign gt       = !lt && !eq;
  assign jump     = |(cond & COND_JMP & {lt, eq, gt});

endmodule

// File: rtl/serial_cond_eval.sv
// Streams a signed multi-word number LS word first, then holds lt/eq/gt and
// the evaluated jump condition until the consumer takes the result.
module serial_cond_eval
  import serial_cond_eval_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 4
) (
  input logic              clk,
  input logic              rst,
  serial_cond_eval_if.slave bus
);

  localparam int             CW       = cw_of(MAX_WORDS);
  localparam logic [CW-1:0]  LAST_CNT = CW'(MAX_WORDS - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          zero_acc;
  logic [2:0]    cond_reg;

  logic          ready_r;
  logic          valid_r;
  logic          lt_r;
  logic          eq_r;
  logic          gt_r;
  logic          jump_r;
  logic          err_r;
  logic [CW-1:0] words_r;

  logic signed [WIDTH-1:0] data;
  logic          first_word;
  logic          at_max;
  logic          final_word;
  logic [2:0]    cond_sel;
  logic [CW-1:0] count_inc;
  logic          zero_nxt;
  logic          lt_c;
  logic          eq_c;
  logic          gt_c;
  logic          jump_c;

  assign data       = bus.in_data;
  assign first_word = (count == '0);
  assign at_max     = (count == LAST_CNT);
  assign final_word = bus.in_last || at_max;
  // The jump mask is only captured with the first word; later in_cond is ignored.
  assign cond_sel   = first_word ? bus.in_cond : cond_reg;
  assign count_inc  = count + CW'(1);

  word_flag_slice #(.WIDTH(WIDTH)) u_slice (
    .data     (data),
    .zero_in  (zero_acc),
    .cond     (cond_sel),
    .zero_out (zero_nxt),
    .lt       (lt_c),
    .eq       (eq_c),
    .gt       (gt_c),
    .jump     (jump_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      count    <= '0;
      zero_acc <= 1'b1;
      cond_reg <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      lt_r     <= 1'b0;
      eq_r     <= 1'b0;
      gt_r     <= 1'b0;
      jump_r   <= 1'b0;
      err_r    <= 1'b0;
      words_r  <= '0;
    end else begin
      case (state)
        ACC: begin
          if (bus.in_valid && ready_r) begin
            if (first_word) cond_reg <= bus.in_cond;
            zero_acc <= zero_nxt;
            count    <= count_inc;
            if (final_word) begin
              lt_r    <= lt_c;
              eq_r    <= eq_c;
              gt_r    <= gt_c;
              jump_r  <= jump_c;
              words_r <= count_inc;
              err_r   <= at_max && !bus.in_last;
              valid_r <= 1'b1;
              ready_r <= 1'b0;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          // Flags are left as-is after the handshake; only control is rearmed.
          if (bus.out_ready) begin
            state    <= ACC;
            count    <= '0;
            zero_acc <= 1'b1;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.out_valid = valid_r;
  assign bus.out_lt    = lt_r;
  assign bus.out_eq    = eq_r;
  assign bus.out_gt    = gt_r;
  assign bus.out_jump  = jump_r;
  assign bus.out_words = words_r;
  assign bus.out_err   = err_r;

endmodule
